// File: rtl/tlc_pkg.sv
// Shared types and constants for the sensor conditioner.
// Holds the request FSM states and wait-counter width.
package tlc_pkg;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } req_state_e;

  localparam int DB_LEN_DEF = 4;
  localparam int WAIT_W     = 8;

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: synchronizer, debouncer, request FSM.
// SENSOR_WAIT_COUNT_EN adds a saturating pending-time counter.
module debounce_channel
  import tlc_pkg::*;
#(
  parameter int DB_LEN = DB_LEN_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              raw_i,
  input  logic              ack_i,
`ifdef SENSOR_WAIT_COUNT_EN
  output logic [WAIT_W-1:0] wait_o,
`endif
  output logic              level_o,
  output logic              req_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_state_e       st_q, st_d;
  logic             rise;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DB_LEN - 1)) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign rise = level_q & ~prev_q;

  // A rise in the same cycle as an ack keeps the request.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      REQ_IDLE: if (rise) st_d = REQ_PEND;
      REQ_PEND: if (!rise && ack_i) st_d = REQ_IDLE;
      default:  st_d = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      st_q    <= REQ_IDLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  assign level_o = level_q;
  assign req_o   = (st_q == REQ_PEND);

`ifdef SENSOR_WAIT_COUNT_EN
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (st_q == REQ_PEND) begin
      if (st_d == REQ_IDLE) begin
        wait_d = '0;
      end else if (tick_i && (wait_q != '1)) begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_o = wait_q;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Two independent debounced sensor channels for the light controller.
// SENSOR_WAIT_COUNT_EN adds north_wait/east_wait outputs.
module sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DB_LEN = DB_LEN_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_PB0,
  input  logic              sample_tick,
  input  logic              north_raw,
  input  logic              east_raw,
  input  logic              north_ack,
  input  logic              east_ack,
`ifdef SENSOR_WAIT_COUNT_EN
  output logic [WAIT_W-1:0] north_wait,
  output logic [WAIT_W-1:0] east_wait,
`endif
  output logic              north_level,
  output logic              east_level,
  output logic              north_req,
  output logic              east_req,
  output logic              both_req
);

  debounce_channel #(
    .DB_LEN (DB_LEN),
    .CNT_W  (CNT_W)
  ) u_north (
    .clk_i   (CLOCK_50),
    .rst_i   (reset_PB0),
    .tick_i  (sample_tick),
    .raw_i   (north_raw),
    .ack_i   (north_ack),
`ifdef SENSOR_WAIT_COUNT_EN
    .wait_o  (north_wait),
`endif
    .level_o (north_level),
    .req_o   (north_req)
  );

  debounce_channel #(
    .DB_LEN (DB_LEN),
    .CNT_W  (CNT_W)
  ) u_east (
    .clk_i   (CLOCK_50),
    .rst_i   (reset_PB0),
    .tick_i  (sample_tick),
    .raw_i   (east_raw),
    .ack_i   (east_ack),
`ifdef SENSOR_WAIT_COUNT_EN
    .wait_o  (east_wait),
`endif
    .level_o (east_level),
    .req_o   (east_req)
  );

  assign both_req = north_req & east_req;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (DB_LEN=4).
// Table vectors, corner sequences and a random run vs a model.
module tb_sensor_conditioner;

  localparam int DBL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic nraw = 1'b0, eraw = 1'b0;
  logic nack = 1'b0, eack = 1'b0;
  logic nlev, elev, nreq, ereq, breq;
`ifdef SENSOR_WAIT_COUNT_EN
  logic [7:0] nwait, ewait;
`endif

  int total = 0;
  int bad = 0;

  sensor_conditioner #(.DB_LEN(DBL), .CNT_W(8)) dut (
    .CLOCK_50    (clk),
    .reset_PB0   (rst),
    .sample_tick (tick),
    .north_raw   (nraw),
    .east_raw    (eraw),
    .north_ack   (nack),
    .east_ack    (eack),
`ifdef SENSOR_WAIT_COUNT_EN
    .north_wait  (nwait),
    .east_wait   (ewait),
`endif
    .north_level (nlev),
    .east_level  (elev),
    .north_req   (nreq),
    .east_req    (ereq),
    .both_req    (breq)
  );

  always #5 clk = ~clk;

  // Reference model: raw history, run of disagreeing ticks,
  // level, previous level, request flag and pending-tick count.
  int m_h1[2], m_h2[2], m_lev[2], m_prev[2];
  int m_run[2], m_req[2], m_wait[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int raw, ack, rise, nq, nw, nl, nr;
    for (int c = 0; c < 2; c++) begin
      raw = (c == 0) ? int'(nraw) : int'(eraw);
      ack = (c == 0) ? int'(nack) : int'(eack);
      if (rst) begin
        m_h1[c] = 0; m_h2[c] = 0; m_lev[c] = 0; m_prev[c] = 0;
        m_run[c] = 0; m_req[c] = 0; m_wait[c] = 0;
      end else begin
        rise = (m_lev[c] == 1 && m_prev[c] == 0) ? 1 : 0;
        nq = rise ? 1 : (ack ? 0 : m_req[c]);
        nw = m_wait[c];
        if (m_req[c] == 1 && nq == 0) nw = 0;
        else if (m_req[c] == 1 && tick) nw = (nw < 255) ? nw + 1 : 255;
        nl = m_lev[c];
        nr = m_run[c];
        if (tick) begin
          if (m_h2[c] != m_lev[c]) begin
            nr = nr + 1;
            if (nr >= DBL) begin
              nl = 1 - nl;
              nr = 0;
            end
          end else begin
            nr = 0;
          end
        end
        m_prev[c] = m_lev[c];
        m_lev[c] = nl;
        m_run[c] = nr;
        m_req[c] = nq;
        m_wait[c] = nw;
        m_h2[c] = m_h1[c];
        m_h1[c] = raw;
      end
    end
  endtask

  task automatic model_cmp();
    chk("m_north_level", int'(nlev), m_lev[0]);
    chk("m_east_level", int'(elev), m_lev[1]);
    chk("m_north_req", int'(nreq), m_req[0]);
    chk("m_east_req", int'(ereq), m_req[1]);
    chk("m_both_req", int'(breq), m_req[0] & m_req[1]);
`ifdef SENSOR_WAIT_COUNT_EN
    chk("m_north_wait", int'(nwait), m_wait[0]);
    chk("m_east_wait", int'(ewait), m_wait[1]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      repeat (9) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic n;
    logic e;
    int   ticks;
    logic exp_n;
    logic exp_e;
  } vec_t;

  vec_t tbl[7];
  bit   hit;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 3, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 3, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1, 1'b1, 1'b0};

    do_reset();
    chk("reset_north_level", int'(nlev), 0);
    chk("reset_east_level", int'(elev), 0);
    chk("reset_north_req", int'(nreq), 0);
    chk("reset_east_req", int'(ereq), 0);
    chk("reset_both_req", int'(breq), 0);

    for (int i = 0; i < 7; i++) begin
      nraw = tbl[i].n;
      eraw = tbl[i].e;
      run_ticks(tbl[i].ticks);
      chk($sformatf("tbl%0d_north_level", i), int'(nlev), int'(tbl[i].exp_n));
      chk($sformatf("tbl%0d_east_level", i), int'(elev), int'(tbl[i].exp_e));
    end

    // ack clears a pending request; a second ack does nothing
    step();
    chk("s3_req_before_ack", int'(nreq), 1);
    nack = 1'b1; step(); nack = 1'b0;
    chk("s3_req_after_ack", int'(nreq), 0);
    nack = 1'b1; step(); nack = 1'b0;
    chk("s3_req_idle_ack", int'(nreq), 0);
    step();
    chk("s3_req_stays_idle", int'(nreq), 0);

    // exact latency from raw edge to level and request
    nraw = 1'b0; eraw = 1'b0;
    do_reset();
    nraw = 1'b1;
    run_ticks(3);
    chk("s1_level_after_3", int'(nlev), 0);
    repeat (9) step();
    tick = 1'b1; step(); tick = 1'b0;
    chk("s1_level_after_4", int'(nlev), 1);
    chk("s1_req_same_cycle", int'(nreq), 0);
    step();
    chk("s1_req_next_cycle", int'(nreq), 1);

    // short pulse is rejected
    nraw = 1'b0;
    do_reset();
    nraw = 1'b1;
    run_ticks(2);
    nraw = 1'b0;
    run_ticks(4);
    chk("s2_level", int'(nlev), 0);
    chk("s2_req", int'(nreq), 0);

    // rise coincident with ack keeps east pending
    do_reset();
    eraw = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      run_ticks(1);
      if (elev) hit = 1'b1;
    end
    chk("s4_east_level_seen", int'(hit), 1);
    eack = 1'b1; step(); eack = 1'b0;
    chk("s4_east_req_set_wins", int'(ereq), 1);
    nraw = 1'b1;
    run_ticks(4);
    step();
    chk("s4_north_req", int'(nreq), 1);
    chk("s4_both_req", int'(breq), 1);

    // reset mid-debounce with raw held high
    nraw = 1'b0; eraw = 1'b0;
    do_reset();
    nraw = 1'b1;
    run_ticks(2);
    rst = 1'b1; step();
    chk("s5_level_in_reset", int'(nlev), 0);
    chk("s5_req_in_reset", int'(nreq), 0);
    chk("s5_both_in_reset", int'(breq), 0);
    rst = 1'b0; step();
    chk("s5_req_first_cycle", int'(nreq), 0);
    run_ticks(3);
    chk("s5_level_after_3", int'(nlev), 0);
    run_ticks(1);
    chk("s5_level_after_4", int'(nlev), 1);
    step();
    chk("s5_req_after_rise", int'(nreq), 1);

`ifdef SENSOR_WAIT_COUNT_EN
    nraw = 1'b0; eraw = 1'b0;
    do_reset();
    eraw = 1'b1;
    run_ticks(4);
    step();
    chk("s6_east_req", int'(ereq), 1);
    tick = 1'b1;
    repeat (300) step();
    tick = 1'b0;
    chk("s6_east_wait_sat", int'(ewait), 255);
    eack = 1'b1; step(); eack = 1'b0;
    chk("s6_east_req_clr", int'(ereq), 0);
    chk("s6_east_wait_clr", int'(ewait), 0);
`endif

    // random traffic against the model
    nraw = 1'b0; eraw = 1'b0;
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) nraw = ~nraw;
      if ($urandom_range(0, 39) == 0) eraw = ~eraw;
      nack = ($urandom_range(0, 7) == 0);
      eack = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    tick = 1'b0; nack = 1'b0; eack = 1'b0; rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
